// File: rtl/head_table_pkg.sv
// Shared widths and types for the hash-table lookup pipeline.
package hash_table;

  localparam int KEY_WIDTH      = 16;
  localparam int VALUE_WIDTH    = 32;
  localparam int BUCKET_WIDTH   = 8;
  localparam int HEAD_PTR_WIDTH = 12;
  localparam int TABLE_DEPTH    = 2**BUCKET_WIDTH;

  typedef enum logic [1:0] {
    CMD_LOOKUP,
    CMD_INSERT,
    CMD_DELETE,
    CMD_UPDATE
  } cmd_t;

  // One head-RAM entry: chain head pointer plus "chain non-empty" flag.
  typedef struct packed {
    logic [HEAD_PTR_WIDTH-1:0] head_ptr;
    logic                      head_ptr_val;
  } head_ram_data_t;

  // Request fields carried unchanged through the head-table stage.
  typedef struct packed {
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    cmd_t                    cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
  } ht_req_t;

  typedef enum logic {
    INIT,
    RUN
  } head_table_state_t;

endpackage

// File: rtl/head_table_if.sv
// Valid/ready request bus between hash-table pipeline stages.
interface ht_if import hash_table::*; ();

  logic                      valid;
  logic                      ready;
  logic [KEY_WIDTH-1:0]      key;
  logic [VALUE_WIDTH-1:0]    value;
  cmd_t                      cmd;
  logic [BUCKET_WIDTH-1:0]   bucket;
  logic [HEAD_PTR_WIDTH-1:0] head_ptr;
  logic                      head_ptr_val;

  modport master (
    output valid, key, value, cmd, bucket, head_ptr, head_ptr_val,
    input  ready
  );

  modport slave (
    input  valid, key, value, cmd, bucket, head_ptr, head_ptr_val,
    output ready
  );

endinterface

// File: rtl/head_table_ram.sv
// Simple dual-port head RAM: one write port, one registered read port.
// A same-address write and read returns the old contents.
module head_ram import hash_table::*; (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [BUCKET_WIDTH-1:0] waddr_i,
  input  head_ram_data_t          wdata_i,
  input  logic                    re_i,
  input  logic [BUCKET_WIDTH-1:0] raddr_i,
  output head_ram_data_t          rdata_o
);

  head_ram_data_t mem_q [TABLE_DEPTH];
  head_ram_data_t rdata_q;

  // Write port and registered read port; read data holds while re_i is low.
  // NOTE: the array and read register have no reset; the owner clears the table by sweeping it after reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q        <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/head_table.sv
// Head-table stage: looks up each request's bucket head pointer and
// forwards the request downstream; applies head updates from the data stage.
module head_table import hash_table::*; (
  input  logic                      clk_i,
  input  logic                      rst_i,
  ht_if.slave                       ht_in,
  ht_if.master                      ht_out,
  input  logic                      wr_en_i,
  input  logic [BUCKET_WIDTH-1:0]   wr_bucket_i,
  input  logic [HEAD_PTR_WIDTH-1:0] wr_head_ptr_i,
  input  logic                      wr_head_ptr_val_i,
  output logic                      init_done_o
);

  head_table_state_t       state_q;
  logic [BUCKET_WIDTH-1:0] init_cnt_q;
  logic                    init_done_q;

  logic           s0_valid_q, s0_valid_d;
  ht_req_t        s0_req_q, s0_req_d;
  logic           s0_byp_q, s0_byp_d;
  head_ram_data_t s0_byp_data_q, s0_byp_data_d;
  logic           s1_valid_q, s1_valid_d;
  ht_req_t        s1_req_q, s1_req_d;
  head_ram_data_t s1_head_q, s1_head_d;

  logic           in_run, stall, accept, wr_act;
  logic           ram_we;
  logic [BUCKET_WIDTH-1:0] ram_waddr;
  head_ram_data_t wr_data, ram_wdata, ram_rdata, s0_head;

  assign in_run  = (state_q == RUN);
  assign stall   = s1_valid_q && !ht_out.ready;
  assign accept  = ht_in.valid && ht_in.ready;
  assign wr_act  = in_run && wr_en_i;
  assign wr_data = '{head_ptr: wr_head_ptr_i, head_ptr_val: wr_head_ptr_val_i};

  // INIT owns the write port to clear the table; afterwards external updates use it.
  assign ram_we    = !in_run || wr_en_i;
  assign ram_waddr = in_run ? wr_bucket_i : init_cnt_q;
  assign ram_wdata = in_run ? wr_data : '0;

  // S0 head: RAM read data unless a write to S0's bucket arrived after the read.
  assign s0_head = s0_byp_q ? s0_byp_data_q : ram_rdata;

  head_ram u_head_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (in_run && !stall),
    .raddr_i (ht_in.bucket),
    .rdata_o (ram_rdata)
  );

  // Init sweep over every bucket, then stay in RUN until reset.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (&init_cnt_q) begin
        state_q     <= RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  // Next state of the two pipeline stages, including write bypasses.
  // NOTE: every signal gets a hold default first so no latch is inferred.
  always_comb begin
    s0_valid_d    = s0_valid_q;
    s0_req_d      = s0_req_q;
    s0_byp_d      = s0_byp_q;
    s0_byp_data_d = s0_byp_data_q;
    s1_valid_d    = s1_valid_q;
    s1_req_d      = s1_req_q;
    s1_head_d     = s1_head_q;
    if (!stall) begin
      s1_valid_d = s0_valid_q;
      if (s0_valid_q) begin
        s1_req_d  = s0_req_q;
        s1_head_d = (wr_act && wr_bucket_i == s0_req_q.bucket) ? wr_data : s0_head;
      end
      s0_valid_d = accept;
      if (accept) begin
        s0_req_d      = '{key: ht_in.key, value: ht_in.value, cmd: ht_in.cmd, bucket: ht_in.bucket};
        // The RAM returns old data on a same-edge write; remember the new value instead.
        s0_byp_d      = wr_act && (wr_bucket_i == ht_in.bucket);
        s0_byp_data_d = wr_data;
      end
    end else begin
      if (wr_act && s0_valid_q && wr_bucket_i == s0_req_q.bucket) begin
        s0_byp_d      = 1'b1;
        s0_byp_data_d = wr_data;
      end
      if (wr_act && wr_bucket_i == s1_req_q.bucket) s1_head_d = wr_data;
    end
  end

  // Pipeline registers; reset drops in-flight requests and clears the output bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid_q    <= 1'b0;
      s0_req_q      <= '0;
      s0_byp_q      <= 1'b0;
      s0_byp_data_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_req_q      <= '0;
      s1_head_q     <= '0;
    end else begin
      s0_valid_q    <= s0_valid_d;
      s0_req_q      <= s0_req_d;
      s0_byp_q      <= s0_byp_d;
      s0_byp_data_q <= s0_byp_data_d;
      s1_valid_q    <= s1_valid_d;
      s1_req_q      <= s1_req_d;
      s1_head_q     <= s1_head_d;
    end
  end

  assign ht_in.ready         = in_run && !stall;
  assign ht_out.valid        = s1_valid_q;
  assign ht_out.key          = s1_req_q.key;
  assign ht_out.value        = s1_req_q.value;
  assign ht_out.cmd          = s1_req_q.cmd;
  assign ht_out.bucket       = s1_req_q.bucket;
  assign ht_out.head_ptr     = s1_head_q.head_ptr;
  assign ht_out.head_ptr_val = s1_head_q.head_ptr_val;
  assign init_done_o         = init_done_q;

endmodule

// File: tb/tb_head_table.sv
// Self-checking bench for head_table: directed scenarios plus a random run
// scored against a per-bucket head model and an in-order request queue.
module tb_head_table;
  import hash_table::*;

  logic                      clk = 1'b0;
  logic                      rst_i;
  logic                      wr_en_i;
  logic [BUCKET_WIDTH-1:0]   wr_bucket_i;
  logic [HEAD_PTR_WIDTH-1:0] wr_head_ptr_i;
  logic                      wr_head_ptr_val_i;
  logic                      init_done_o;

  ht_if u_in ();
  ht_if u_out ();

  head_table dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .ht_in             (u_in),
    .ht_out            (u_out),
    .wr_en_i           (wr_en_i),
    .wr_bucket_i       (wr_bucket_i),
    .wr_head_ptr_i     (wr_head_ptr_i),
    .wr_head_ptr_val_i (wr_head_ptr_val_i),
    .init_done_o       (init_done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]      key;
    logic [VALUE_WIDTH-1:0]    value;
    logic [1:0]                cmd;
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      val;
  } obs_t;

  typedef struct {
    logic [KEY_WIDTH-1:0]    key;
    logic [VALUE_WIDTH-1:0]  value;
    logic [1:0]              cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    int                      cyc;
  } pend_t;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_emit = 0;
  bit  check_lat = 0;
  bit  was_stalled = 0;
  obs_t held, last_out;

  logic [HEAD_PTR_WIDTH-1:0] m_ptr [TABLE_DEPTH];
  bit                        m_val [TABLE_DEPTH];
  pend_t                     exp_q [$];

  function automatic obs_t sample_out();
    obs_t o;
    o.key    = u_out.key;
    o.value  = u_out.value;
    o.cmd    = u_out.cmd;
    o.bucket = u_out.bucket;
    o.ptr    = u_out.head_ptr;
    o.val    = u_out.head_ptr_val;
    return o;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < TABLE_DEPTH; i++) begin
      m_ptr[i] = '0;
      m_val[i] = 1'b0;
    end
  endfunction

  // One clock cycle: drive at negedge, observe/score, take the edge, update the model.
  task automatic step(input bit iv, input logic [BUCKET_WIDTH-1:0] ib, input logic [KEY_WIDTH-1:0] ik,
                      input logic [VALUE_WIDTH-1:0] ival, input logic [1:0] ic, input bit ordy,
                      input bit wv, input logic [BUCKET_WIDTH-1:0] wb, input logic [HEAD_PTR_WIDTH-1:0] wp,
                      input bit wval, output bit acc);
    obs_t  o, e;
    pend_t p;
    bit    in_run;
    u_in.valid = iv; u_in.bucket = ib; u_in.key = ik; u_in.value = ival; u_in.cmd = cmd_t'(ic);
    u_out.ready = ordy;
    wr_en_i = wv; wr_bucket_i = wb; wr_head_ptr_i = wp; wr_head_ptr_val_i = wval;
    #1;
    o = sample_out();
    in_run = init_done_o;
    if (was_stalled) begin
      checks++;
      if (o !== held) begin
        errors++;
        $display("FAIL hold cyc %0d got %h required %h", cyc, o, held);
      end
    end
    if (u_out.valid && !ordy) begin
      checks++;
      if (u_in.ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_in_stall cyc %0d got %b required 0", cyc, u_in.ready);
      end
    end
    if (u_out.valid && ordy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out cyc %0d got %h required no output", cyc, o);
      end else begin
        p = exp_q.pop_front();
        e = '{key: p.key, value: p.value, cmd: p.cmd, bucket: p.bucket,
              ptr: m_ptr[p.bucket], val: m_val[p.bucket]};
        if (o !== e) begin
          errors++;
          $display("FAIL emit cyc %0d got %h required %h", cyc, o, e);
        end
        if (check_lat) begin
          checks++;
          if (cyc - p.cyc != 2) begin
            errors++;
            $display("FAIL latency cyc %0d got %0d required 2", cyc, cyc - p.cyc);
          end
        end
      end
      last_out = o;
      n_emit++;
    end
    acc = iv && u_in.ready;
    if (acc) exp_q.push_back('{key: ik, value: ival, cmd: ic, bucket: ib, cyc: cyc});
    was_stalled = u_out.valid && !ordy && !wv;
    held = o;
    @(posedge clk);
    if (wv && in_run) begin
      m_ptr[wb] = wp;
      m_val[wb] = wval;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(0, '0, '0, '0, '0, 1, 0, '0, '0, 0, a);
  endtask

  task automatic read(input logic [BUCKET_WIDTH-1:0] b, input logic [KEY_WIDTH-1:0] k);
    bit a;
    step(1, b, k, {16'h0, k}, 2'd0, 1, 0, '0, '0, 0, a);
  endtask

  task automatic write(input logic [BUCKET_WIDTH-1:0] b, input logic [HEAD_PTR_WIDTH-1:0] p, input bit v);
    bit a;
    step(0, '0, '0, '0, '0, 1, 1, b, p, v, a);
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      idle(1);
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending required 0", exp_q.size());
    end
  endtask

  // Reset, check the cleared outputs, then count INIT cycles while a write is held (must be ignored).
  task automatic apply_reset(output int init_cycles);
    rst_i = 1'b1;
    u_in.valid = 1'b0; u_out.ready = 1'b1; wr_en_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (u_out.valid !== 1'b0 || init_done_o !== 1'b0 || u_in.ready !== 1'b0 || sample_out() !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b done=%b ready=%b out=%h required all 0",
               u_out.valid, init_done_o, u_in.ready, sample_out());
    end
    exp_q.delete();
    model_clear();
    was_stalled = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    wr_en_i = 1'b1; wr_bucket_i = 8'h55; wr_head_ptr_i = 'd7; wr_head_ptr_val_i = 1'b1;
    init_cycles = 0;
    while (init_cycles < 400) begin
      @(posedge clk); #1;
      init_cycles++;
      if (init_done_o) break;
      if (u_in.ready !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL ready_in_init cyc %0d got %b required 0", init_cycles, u_in.ready);
      end
    end
    wr_en_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    apply_reset(n);
    checks++;
    if (n != TABLE_DEPTH) begin
      errors++;
      $display("FAIL init_cycles got %0d required %0d", n, TABLE_DEPTH);
    end
    checks++;
    if (u_in.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_init got %b required 1", u_in.ready);
    end
    read(8'h00, 16'h0001);
    read(8'h7F, 16'h0002);
    read(8'hFF, 16'h0003);
    read(8'h55, 16'h0004);
    drain();
    checks++;
    if (last_out.val !== 1'b0 || last_out.bucket !== 8'h55) begin
      errors++;
      $display("FAIL init_write_ignored got bucket=%h val=%b required bucket=55 val=0",
               last_out.bucket, last_out.val);
    end
  endtask

  task automatic test_write_read();
    check_lat = 1;
    write(8'h12, 'd5, 1);
    read(8'h12, 16'hABCD);
    drain();
    check_lat = 0;
    checks++;
    if (last_out.ptr !== 'd5 || last_out.val !== 1'b1 || last_out.key !== 16'hABCD || last_out.bucket !== 8'h12) begin
      errors++;
      $display("FAIL write_read got ptr=%0d val=%b key=%h bucket=%h required ptr=5 val=1 key=abcd bucket=12",
               last_out.ptr, last_out.val, last_out.key, last_out.bucket);
    end
  endtask

  task automatic test_bypass();
    bit a;
    step(1, 8'h12, 16'h1111, 32'h1, 2'd1, 1, 1, 8'h12, 'd9, 1, a);
    drain();
    checks++;
    if (last_out.ptr !== 'd9 || last_out.val !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_bypass got ptr=%0d val=%b required ptr=9 val=1", last_out.ptr, last_out.val);
    end
    step(1, 8'h12, 16'h2222, 32'h2, 2'd2, 1, 0, '0, '0, 0, a);
    idle(1);
    step(0, '0, '0, '0, '0, 0, 1, 8'h12, 'd3, 0, a);
    drain();
    checks++;
    if (last_out.val !== 1'b0 || last_out.key !== 16'h2222) begin
      errors++;
      $display("FAIL s1_bypass got key=%h val=%b required key=2222 val=0", last_out.key, last_out.val);
    end
  endtask

  task automatic test_back_to_back();
    int n0, idx, t;
    bit a, ordy;
    n0 = n_emit;
    check_lat = 1;
    for (int i = 1; i <= 16; i++) read(8'(i), 16'(16'h100 + i));
    drain();
    check_lat = 0;
    checks++;
    if (n_emit - n0 != 16) begin
      errors++;
      $display("FAIL b2b_count got %0d required 16", n_emit - n0);
    end
    n0 = n_emit;
    idx = 0;
    t = 0;
    while (idx < 16 && t < 60) begin
      ordy = !(t >= 6 && t < 11);
      step(1, 8'(8'h21 + idx), 16'(16'h200 + idx), 32'(idx), 2'd0, ordy, 0, '0, '0, 0, a);
      if (a) idx++;
      t++;
    end
    drain();
    checks++;
    if (n_emit - n0 != 16) begin
      errors++;
      $display("FAIL stall_count got %0d required 16", n_emit - n0);
    end
  endtask

  task automatic test_random();
    bit a;
    logic [BUCKET_WIDTH-1:0] ib, wb;
    for (int i = 0; i < 10000; i++) begin
      ib = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      wb = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, ib, 16'($urandom), $urandom, 2'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, wb, 12'($urandom), 1'($urandom), a);
    end
    drain();
  endtask

  task automatic test_reset_mid_stream();
    int n;
    bit a;
    for (int i = 0; i < 4; i++) write(8'(8'h60 + i), 12'(i + 1), 1);
    step(1, 8'h60, 16'h3000, 32'h0, 2'd0, 1, 0, '0, '0, 0, a);
    step(1, 8'h61, 16'h3001, 32'h0, 2'd0, 1, 0, '0, '0, 0, a);
    apply_reset(n);
    checks++;
    if (n != TABLE_DEPTH) begin
      errors++;
      $display("FAIL reinit_cycles got %0d required %0d", n, TABLE_DEPTH);
    end
    for (int i = 0; i < 4; i++) read(8'(8'h60 + i), 16'(16'h4000 + i));
    drain();
    checks++;
    if (last_out.val !== 1'b0 || last_out.bucket !== 8'h63) begin
      errors++;
      $display("FAIL cleared_after_reset got bucket=%h val=%b required bucket=63 val=0",
               last_out.bucket, last_out.val);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    u_in.valid = 1'b0; u_in.key = '0; u_in.value = '0; u_in.cmd = CMD_LOOKUP; u_in.bucket = '0;
    u_in.head_ptr = '0; u_in.head_ptr_val = 1'b0;
    u_out.ready = 1'b1;
    wr_en_i = 1'b0; wr_bucket_i = '0; wr_head_ptr_i = '0; wr_head_ptr_val_i = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_back_to_back();
    test_random();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
